// File: rtl/uart_rx_if.sv
// Line-side bundle for the UART receiver: serial input, frame options,
// and the received word with its status pulses.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  // Line driver / consumer side.
  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err
  );

  // Receiver side.
  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_WIDTH data bits LSB first, optional parity,
// one stop bit. Each bit is resolved by a 3-sample majority vote around the
// bit centre. Emits a one-cycle data_valid, par_err or stp_err per frame.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8   // clk cycles per bit, even and >= 4
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int CW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] EDGE_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] SAMP_0    = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] SAMP_1    = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] SAMP_2    = CW'(PRESCALE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [2:0]            samp;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_fail;

  logic                  bit_end;
  logic                  third;
  logic                  bit_val;
  logic                  start_det;

  // With PRESCALE = 4 the last sample coincides with the evaluation edge,
  // so the live line value stands in for the not-yet-registered sample.
  assign bit_end   = (edge_cnt == EDGE_LAST);
  assign third     = (edge_cnt == SAMP_2) ? bus.RX_IN : samp[2];
  assign bit_val   = (samp[0] & samp[1]) | (samp[0] & third) | (samp[1] & third);
  assign start_det = (state == IDLE) && !bus.RX_IN;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; transitions happen only at the end of a bit period.
  always_comb begin
    // NOTE: default first, so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (!bus.RX_IN) state_nxt = START;
      START:   if (bit_end)    state_nxt = bit_val ? IDLE : DATA;
      DATA:    if (bit_end && (bit_cnt == BIT_LAST))
                 state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end)    state_nxt = STOP;
      STOP:    if (bit_end)    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Edge counter: the start-detect cycle is edge 0, so the next one is edge 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                edge_cnt <= '0;
    else if (state == IDLE) edge_cnt <= start_det ? CW'(1) : '0;
    else if (bit_end)       edge_cnt <= '0;
    else                    edge_cnt <= edge_cnt + CW'(1);
  end

  // Data bit counter, live only while shifting data bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     bit_cnt <= '0;
    else if (state != DATA)      bit_cnt <= '0;
    else if (bit_end)            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
  end

  // Centre samples for the majority vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp <= 3'b111;
    end else begin
      if (edge_cnt == SAMP_0) samp[0] <= bus.RX_IN;
      if (edge_cnt == SAMP_1) samp[1] <= bus.RX_IN;
      if (edge_cnt == SAMP_2) samp[2] <= bus.RX_IN;
    end
  end

  // Per-frame context: latched options, shift register, parity check.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the shift register is reset along with control so a frame
    // cut short by reset never leaves stale data in view.
    if (rst) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_fail  <= 1'b0;
      shift     <= '0;
    end else begin
      if (start_det) begin
        par_en_q  <= bus.PAR_EN;
        par_typ_q <= bus.PAR_TYP;
        par_fail  <= 1'b0;
      end
      if ((state == DATA) && bit_end)
        shift <= {bit_val, shift[DATA_WIDTH-1:1]};
      if ((state == PARITY) && bit_end)
        par_fail <= (bit_val != ((^shift) ^ par_typ_q));
    end
  end

  // Registered outputs: one status pulse at the end of the stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.P_DATA     <= '0;
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;
      if ((state == STOP) && bit_end) begin
        if (bit_val && !par_fail) begin
          bus.P_DATA     <= shift;
          bus.data_valid <= 1'b1;
        end else begin
          bus.par_err <= par_fail;
          bus.stp_err <= !bit_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are generated bit by bit, the expected
// status pulse (kind, word, cycle) is queued when a frame starts, and a
// monitor pops and compares whenever the receiver pulses.
module tb_uart_rx;

  localparam int DW = 8;
  localparam int P  = 8;

  typedef struct {
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] data;
    int unsigned   at;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  int unsigned   cyc = 0;
  int            vectors = 0;
  int            fails = 0;
  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] last_good = '0;

  uart_rx_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d, required 0", sb.size());
    $fatal(1, "watchdog");
  end

  // Compare every status pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (bus.data_valid || bus.par_err || bus.stp_err)) begin
      vectors++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL stray_pulse cycle %0d: got dv/pe/se=%b%b%b, required no pulse",
               cyc, bus.data_valid, bus.par_err, bus.stp_err);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        vectors++;
        assert ({bus.data_valid, bus.par_err, bus.stp_err} === {mon_e.dv, mon_e.pe, mon_e.se}) else begin
          fails++;
          $error("FAIL pulse_kind cycle %0d: got dv/pe/se=%b%b%b, required %b%b%b",
                 cyc, bus.data_valid, bus.par_err, bus.stp_err, mon_e.dv, mon_e.pe, mon_e.se);
        end
        vectors++;
        assert (bus.P_DATA === mon_e.data) else begin
          fails++;
          $error("FAIL p_data cycle %0d: got %h, required %h", cyc, bus.P_DATA, mon_e.data);
        end
        vectors++;
        assert (cyc === mon_e.at) else begin
          fails++;
          $error("FAIL pulse_cycle: got %0d, required %0d", cyc, mon_e.at);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit period; optionally inverts the line for one cycle at glitch_edge.
  task automatic drive_bit(input logic b, input int glitch_edge);
    for (int e = 0; e < P; e++) begin
      bus.RX_IN = (e == glitch_edge) ? ~b : b;
      tick();
    end
  endtask

  task automatic check_outputs_zero(input int step);
    vectors++;
    assert ({bus.P_DATA, bus.data_valid, bus.par_err, bus.stp_err} === '0) else begin
      fails++;
      $error("FAIL reset_outputs step %0d: got P_DATA=%h dv/pe/se=%b%b%b, required all 0",
             step, bus.P_DATA, bus.data_valid, bus.par_err, bus.stp_err);
    end
  endtask

  // Full frame starting in the current cycle. Options are flipped after the
  // start bit to show they only matter at start detection.
  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                            input logic pbit, input logic stop,
                            input int gl_bit, input int gl_edge);
    exp_t        e;
    logic        pfail;
    pfail = pen && (pbit !== ((^d) ^ ptyp));
    e.at  = cyc + unsigned'((2 + DW + int'(pen)) * P);
    if (stop && !pfail) begin
      e.dv = 1'b1; e.pe = 1'b0; e.se = 1'b0;
      last_good = d;
    end else begin
      e.dv = 1'b0; e.pe = pfail; e.se = !stop;
    end
    e.data = last_good;
    sb.push_back(e);
    bus.PAR_EN  = pen;
    bus.PAR_TYP = ptyp;
    drive_bit(1'b0, -1);
    bus.PAR_EN  = ~pen;
    bus.PAR_TYP = ~ptyp;
    for (int i = 0; i < DW; i++) drive_bit(d[i], (gl_bit == i) ? gl_edge : -1);
    if (pen) drive_bit(pbit, -1);
    drive_bit(stop, -1);
  endtask

  initial begin
    logic [DW-1:0] aborted;
    bus.RX_IN   = 1'b1;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    rst         = 1'b1;
    repeat (3) tick();
    check_outputs_zero(0);
    rst = 1'b0;
    repeat (4) tick();

    // Plain frame, then parity good/bad/odd.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);

    // Stop bit low, then line held low: repeated stop errors,
    // last one with a parity failure as well.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);
    bus.RX_IN = 1'b1;
    repeat (4) tick();

    // Two-cycle idle glitch; receiver must be idle again 8 cycles later.
    bus.RX_IN = 1'b0;
    repeat (2) tick();
    bus.RX_IN = 1'b1;
    repeat (P - 2) tick();
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);

    // Single-cycle glitches inside data bits, outvoted by the majority.
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1, 4);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0, 5);
    repeat (3) tick();

    // Back-to-back: second start lands in the first frame's pulse cycle.
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    send_frame(8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    repeat (4) tick();

    // Reset 40 cycles into a frame; that frame must never report.
    aborted = 8'h33;
    for (int c = 0; c < 40; c++) begin
      bus.RX_IN = (c < P) ? 1'b0 : aborted[c / P - 1];
      tick();
    end
    rst       = 1'b1;
    bus.RX_IN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      check_outputs_zero(c + 1);
      tick();
    end
    rst       = 1'b0;
    last_good = '0;
    repeat (20) tick();
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);

    // Drain the scoreboard under a cycle budget, then watch for stray pulses.
    for (int i = 0; (i < 400) && (sb.size() != 0); i++) tick();
    repeat (20) tick();
    vectors++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL drain: got %0d pending pulses, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link, the counterpart of the transmit path. It recovers frames from the serial line using a fixed oversampling ratio and majority-vote sampling. Each frame is a start bit, DATA_WIDTH data bits LSB first, an optional parity bit and one stop bit. It outputs the parallel word with a one-cycle valid pulse and flags parity and stop-bit errors; it sits between the line interface and the system-side consumer.

## Interface
- DATA_WIDTH, 8: data bits per frame.
- PRESCALE, 8: clk cycles per bit period; must be even and >= 4.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- RX_IN  input  1  serial line, idle high, already synchronous to clk (no internal synchronizer).
- PAR_EN  input  1  1 = frame carries a parity bit after the data.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  last good received word.
- data_valid  output  1  one-cycle pulse: P_DATA updated with an error-free frame.
- par_err  output  1  one-cycle pulse: frame parity mismatch.
- stp_err  output  1  one-cycle pulse: stop bit sampled low.

## Operation
- Line levels: start bit = 0, stop bit = 1, idle = 1.
- States: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - Edge counter 0..PRESCALE-1 within the current bit.
  - Bit counter 0..DATA_WIDTH-1 in DATA.
- Sampling:
  - Three samples per bit at edge counts PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - The bit value is the majority of the three.
  - The bit is evaluated at edge count PRESCALE-1, where the state transition occurs.
- IDLE:
  - RX_IN = 0 in a cycle moves the FSM to START; that cycle counts as edge 0 of the start bit.
  - PAR_EN and PAR_TYP are latched in the same cycle and held for the whole frame.
- START:
  - Majority 0: go to DATA.
  - Majority 1 (false start/glitch): go to IDLE with no output pulse.
- DATA: each bit is shifted in LSB first. After bit DATA_WIDTH-1, go to PARITY if latched PAR_EN = 1, else STOP.
- PARITY:
  - The expected bit is the XOR of the data for even parity, or its inverse for odd parity.
  - A mismatch sets an internal parity-fail flag.
  - The frame continues to STOP regardless.
- STOP: at edge PRESCALE-1, return to IDLE and drive exactly one of:
  - stop majority 1 and no parity fail: P_DATA <= shift register and data_valid = 1;
  - otherwise: par_err = parity-fail flag and stp_err = (stop majority == 0).
  - P_DATA is not updated on any error. par_err and stp_err may pulse together.
- P_DATA holds its value between good frames.
- A line held low (break) after a stp_err frame re-triggers START immediately. Each such frame reports stp_err, plus par_err if the parity also fails. No data_valid is produced.

## Timing
- Reset (async, any state): FSM to IDLE, counters 0, P_DATA = 0, data_valid = 0, par_err = 0, stp_err = 0, parity-fail flag cleared. Release mid-frame resumes in IDLE; the rest of the interrupted frame is treated as a new frame, so bits after release may be misread until the line has been idle.
- Frame length N = 2 + DATA_WIDTH + PAR_EN bits, so N*PRESCALE clk cycles.
- Start detected in cycle t: the status pulse (data_valid, par_err or stp_err) is high during cycle t + N*PRESCALE, for exactly one cycle.
- Status outputs are registered; they are never high outside that single cycle.
- Back-to-back frames:
  - The FSM is in IDLE during the pulse cycle. RX_IN = 0 in that cycle starts the next frame with no lost cycle.
  - Sustained throughput is one frame per N*PRESCALE cycles.
- PAR_EN/PAR_TYP changes mid-frame have no effect until the next start detection.
- False start: a low pulse shorter than 2 of the 3 centre samples returns the FSM to IDLE at cycle t + PRESCALE - 1 + 1. Line monitoring resumes in that cycle.

## Test plan
- 0xA5, PAR_EN = 0, PRESCALE = 8, frame driven from cycle 0 → data_valid high only in cycle 80, P_DATA = 0xA5, par_err = stp_err = 0 throughout.
- 0x3C, PAR_EN = 1:
  - PAR_TYP = 0 with parity bit 0 → data_valid at cycle 88, P_DATA = 0x3C.
  - Same frame with parity bit 1 → par_err pulse at cycle 88, no data_valid, P_DATA unchanged.
- 0x5A with stop bit driven 0 → stp_err pulse at cycle 80 with no data_valid. Line then held low → repeated stp_err every 80 cycles.
- Glitches on idle line:
  - 2-cycle low glitch → no pulses, FSM back in IDLE by cycle 8.
  - 1-cycle low glitch at edge 4 of a data bit → bit still read correctly by majority.
- Back-to-back 0x11 then 0xEE, the second start bit beginning in the first frame's pulse cycle → data_valid at cycles 80 and 160 with P_DATA = 0x11 then 0xEE.
- rst asserted at cycle 40 of a frame for 3 cycles, line then idle high for 20 cycles, then 0x7E sent → all outputs 0 during reset, no pulse from the aborted frame, 0x7E received correctly.
